// File: rtl/sign_mag_accumulator_if.sv
// rtl/sign_mag_accumulator_if.sv - sample input and result output handshake bundle
interface sign_mag_accumulator_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  // upstream producer / downstream consumer side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // accumulator side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/sign_mag_accumulator.sv
// rtl/sign_mag_accumulator.sv - sums SAMPLES sign-magnitude inputs into one sign-magnitude result; SM_ACC_SATURATE_EN selects clamping adds
module sign_mag_accumulator #(
  parameter int WIDTH   = 4,
  parameter int ACC_W   = 8,
  parameter int SAMPLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sign_mag_accumulator_if.slave bus
);

  if (ACC_W < WIDTH) begin : g_bad_acc_w
    $error("ACC_W must be >= WIDTH");
  end
  if (SAMPLES < 1) begin : g_bad_samples
    $error("SAMPLES must be >= 1");
  end

  localparam int CNT_W = $clog2(SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES - 1);
  // magnitude of the most negative input code (sign=1, mag=0)
  localparam logic [ACC_W:0] NEG_FULL = (ACC_W + 1)'(1) << (WIDTH - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_q, out_d;

  logic             in_sign;
  logic [WIDTH-2:0] in_mag;
  logic [ACC_W:0]   mag_ext;
  logic [ACC_W:0]   dec_val;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] enc_val;
  logic             xfer;

  assign in_sign = bus.in_data[WIDTH-1];
  assign in_mag  = bus.in_data[WIDTH-2:0];
  assign mag_ext = {{(ACC_W + 2 - WIDTH){1'b0}}, in_mag};

  // decode the sample and add it to the sign-extended accumulator at ACC_W+1 bits
  always_comb begin
    dec_val = mag_ext;
    if (in_sign) begin
      dec_val = (in_mag == '0) ? -NEG_FULL : -mag_ext;
    end
    sum = {acc_q[ACC_W-1], acc_q} + dec_val;
  end

`ifdef SM_ACC_SATURATE_EN
  localparam logic [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W - 1){1'b1}}};
  localparam logic [ACC_W:0] SAT_MIN = -SAT_MAX;

  // clamp to the symmetric range so the result never encodes as negative zero
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if ($signed(sum) > $signed(SAT_MAX)) begin
      acc_next = SAT_MAX[ACC_W-1:0];
    end else if ($signed(sum) < $signed(SAT_MIN)) begin
      acc_next = SAT_MIN[ACC_W-1:0];
    end
  end
`else
  logic unused_sum_msb;
  assign unused_sum_msb = sum[ACC_W];

  // modulo-2^ACC_W wrap
  always_comb begin
    acc_next = sum[ACC_W-1:0];
  end
`endif

  // two's complement total -> sign-magnitude; the most negative total becomes sign=1, mag=0
  always_comb begin
    enc_val = acc_next;
    if (acc_next[ACC_W-1]) begin
      enc_val = {1'b1, -acc_next[ACC_W-2:0]};
    end
  end

  assign xfer = bus.in_valid && (state_q == ACCUM);

  // next-state and datapath control for the ACCUM/HOLD handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      ACCUM: begin
        if (xfer) begin
          if (cnt_q == LAST_CNT) begin
            out_d   = enc_val;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM) && !rst_i;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_sign_mag_accumulator.sv
// tb/tb_sign_mag_accumulator.sv - directed self-checking bench for sign_mag_accumulator
module tb_sign_mag_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  sign_mag_accumulator_if #(.WIDTH(4), .ACC_W(8)) b1 ();
  sign_mag_accumulator_if #(.WIDTH(8), .ACC_W(8)) b2 ();

  sign_mag_accumulator #(.WIDTH(4), .ACC_W(8), .SAMPLES(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b1)
  );

  sign_mag_accumulator #(.WIDTH(8), .ACC_W(8), .SAMPLES(2)) u_dut_w8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    int n;
    n = 0;
    b1.in_data  = d;
    b1.in_valid = 1'b1;
    while (!b1.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", 32'(n), 32'd0);
    tick();
    b1.in_valid = 1'b0;
  endtask

  task automatic take();
    b1.out_ready = 1'b1;
    tick();
    b1.out_ready = 1'b0;
    check("take_out_valid", 32'(b1.out_valid), 32'd0);
    check("take_in_ready", 32'(b1.in_ready), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(b1.out_valid), 32'd1);
    check({tag, "_data"}, 32'(b1.out_data), 32'(exp));
    check({tag, "_in_ready"}, 32'(b1.in_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    b1.in_data = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;
    b2.in_data = '0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;

    // reset held three cycles
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out_valid", 32'(b1.out_valid), 32'd0);
      check("rst_out_data", 32'(b1.out_data), 32'h00);
      check("rst_in_ready", 32'(b1.in_ready), 32'd0);
    end
    check("rst_w8_out_valid", 32'(b2.out_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(b1.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(b1.out_valid), 32'd0);

    // mixed signs: 3 + 5 - 2 + 1 = 7
    push(4'h3); push(4'h5); push(4'hA);
    check("mixed_no_early_valid", 32'(b1.out_valid), 32'd0);
    push(4'h1);
    expect_result("mixed", 8'h07);
    take();

    // most negative input code: 4 x -8 = -32
    push(4'h8); push(4'h8); push(4'h8); push(4'h8);
    expect_result("neg_full", 8'hA0);
    take();

    // zeros decode as +0: 0 - 8 + 0 + 0 = -8
    push(4'h0); push(4'h8); push(4'h0); push(4'h0);
    expect_result("zeros", 8'h88);
    take();

    // overflow behaviour on the 8-bit wide instance: 127 + 127
    b2.in_data  = 8'h7F;
    b2.in_valid = 1'b1;
    check("w8_ready0", 32'(b2.in_ready), 32'd1);
    tick();
    check("w8_ready1", 32'(b2.in_ready), 32'd1);
    tick();
    b2.in_valid = 1'b0;
    check("w8_valid", 32'(b2.out_valid), 32'd1);
`ifdef SM_ACC_SATURATE_EN
    check("w8_sat_data", 32'(b2.out_data), 32'h7F);
`else
    check("w8_wrap_data", 32'(b2.out_data), 32'h82);
`endif
    b2.out_ready = 1'b1;
    tick();
    b2.out_ready = 1'b0;
    check("w8_take", 32'(b2.out_valid), 32'd0);

    // pending result ignores input for 5 cycles: 1+2+3+4 = 10
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    expect_result("hold", 8'h0A);
    held = b1.out_data;
    b1.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b1.in_data = 4'(i + 5);
      tick();
      check("hold_stable", 32'(b1.out_data), 32'(held));
      check("hold_in_ready", 32'(b1.in_ready), 32'd0);
    end
    check("hold_still_valid", 32'(b1.out_valid), 32'd1);
    b1.in_valid = 1'b0;
    take();
    push(4'h2); push(4'h2); push(4'h2); push(4'h2);
    expect_result("after_hold", 8'h08);
    take();

    // reset mid-accumulation discards partial sum
    push(4'h7); push(4'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 32'(b1.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      push(4'h1);
      if (i < 3) check("midrst_no_early", 32'(b1.out_valid), 32'd0);
    end
    expect_result("midrst", 8'h04);
    take();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
